regfile_arbiter: RTL

Two-port arbiter and sequencer in front of the 32 x 8-bit dual-lane register file. It shares the register file's single read/write port pair between the core pipeline (port 0) and the debug/context-save unit (port 1). Each cycle it accepts at most one access, drives the register-file controls from registers, and routes read data back to the requester that issued the access. Port 1 is protected from starvation by an age counter and can optionally lock the file for multi-beat sequences.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rf_rsp_pipe.sv | 58 +++++
 rtl/regfile_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter slice.
package regfile_pkg;

    localparam int RF_ADDR_W      = 5;
    localparam int RF_LANE_W      = 8;
    localparam int RF_LANES       = 2;
    localparam int RF_DATA_W      = RF_LANE_W * RF_LANES;
    localparam int RF_PAIR_ADDR_W = RF_ADDR_W * RF_LANES;

    typedef struct packed {
        logic [RF_LANES-1:0]       wr_en;
        logic [RF_LANES-1:0]       rd_en;
        logic [RF_PAIR_ADDR_W-1:0] wr_addr;
        logic [RF_PAIR_ADDR_W-1:0] rd_addr;
        logic [RF_DATA_W-1:0]      wdata;
    } rf_req_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rf_rsp_pipe.sv
// Two-stage {valid, port} tracker for accepted reads; masks unread lanes and
// presents the read data two edges after acceptance.
module rf_rsp_pipe
    import regfile_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 acc_valid,
    input  logic                 acc_port,
    input  logic [RF_LANES-1:0]  acc_rd_en,
    input  logic [RF_DATA_W-1:0] rf_data_out,
    output logic [1:0]           rsp_valid,
    output logic [RF_DATA_W-1:0] rsp_rdata
);

    logic                 s1_valid_reg;
    logic                 s1_port_reg;
    logic [RF_LANES-1:0]  s1_rd_en_reg;
    logic                 s2_valid_reg;
    logic                 s2_port_reg;
    logic [RF_DATA_W-1:0] s2_rdata_reg;
    logic [RF_DATA_W-1:0] lane_data;

    // rf_data_out is valid one edge after acceptance; lanes not read return zero
    generate
        for (genvar gi = 0; gi < RF_LANES; gi++) begin : g_lane
            assign lane_data[gi*RF_LANE_W +: RF_LANE_W] =
                s1_rd_en_reg[gi] ? rf_data_out[gi*RF_LANE_W +: RF_LANE_W] : '0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_port_reg  <= 1'b0;
            s1_rd_en_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_port_reg  <= 1'b0;
            s2_rdata_reg <= '0;
            rsp_valid    <= 2'b00;
            rsp_rdata    <= '0;
        end else begin
            s1_valid_reg <= acc_valid;
            s1_port_reg  <= acc_port;
            s1_rd_en_reg <= acc_rd_en;
            s2_valid_reg <= s1_valid_reg;
            s2_port_reg  <= s1_port_reg;
            if (s1_valid_reg) begin
                s2_rdata_reg <= lane_data;
            end
            rsp_valid <= {s2_valid_reg && s2_port_reg, s2_valid_reg && !s2_port_reg};
            if (s2_valid_reg) begin
                rsp_rdata <= s2_rdata_reg;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-port arbiter/sequencer sharing the register file between core (port 0) and debug (port 1).
// Define REGFILE_ARB_LOCK_EN to add req_lock1 and the port-1 lock FSM.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 7,
    parameter int CNT_W        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr_en0,
    input  logic [1:0]  req_wr_en1,
    input  logic [1:0]  req_rd_en0,
    input  logic [1:0]  req_rd_en1,
    input  logic [9:0]  req_wr_addr0,
    input  logic [9:0]  req_wr_addr1,
    input  logic [9:0]  req_rd_addr0,
    input  logic [9:0]  req_rd_addr1,
    input  logic [15:0] req_wdata0,
    input  logic [15:0] req_wdata1,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic        req_lock1,
`endif
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rf_wr_en,
    output logic [1:0]  rf_rd_en,
    output logic [9:0]  rf_wr_addr,
    output logic [9:0]  rf_rd_addr,
    output logic [15:0] rf_data_in,
    input  logic [15:0] rf_data_out
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    rf_req_t          req [2];
    rf_req_t          sel;
    logic [1:0]       grant;
    logic             xfer;
    logic             locked;
    logic [CNT_W-1:0] starve_cnt_reg;

    assign req[0] = '{wr_en: req_wr_en0, rd_en: req_rd_en0, wr_addr: req_wr_addr0,
                      rd_addr: req_rd_addr0, wdata: req_wdata0};
    assign req[1] = '{wr_en: req_wr_en1, rd_en: req_rd_en1, wr_addr: req_wr_addr1,
                      rd_addr: req_rd_addr1, wdata: req_wdata1};

    always_comb begin
        grant = 2'b00;
        if (reset) begin
            grant = 2'b00;
        end else if (locked) begin
            grant = {req_valid[1], 1'b0};
        end else if (req_valid == 2'b11) begin
            grant = (starve_cnt_reg == STARVE_MAX) ? 2'b10 : 2'b01;
        end else begin
            grant = req_valid;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign sel       = grant[1] ? req[1] : req[0];

`ifdef REGFILE_ARB_LOCK_EN
    lock_state_t lock_state_reg;

    assign locked = (lock_state_reg == LOCKED);

    // While locked, port 1 always wins whenever valid, so any idle cycle or unlocking beat releases
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_state_reg <= UNLOCKED;
        end else begin
            case (lock_state_reg)
                UNLOCKED: if (grant[1] && req_lock1) lock_state_reg <= LOCKED;
                LOCKED:   if (!req_valid[1] || !req_lock1) lock_state_reg <= UNLOCKED;
                default:  lock_state_reg <= UNLOCKED;
            endcase
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (locked || !req_valid[1] || grant[1]) begin
            starve_cnt_reg <= '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wr_en   <= 2'b00;
            rf_rd_en   <= 2'b00;
            rf_wr_addr <= '0;
            rf_rd_addr <= '0;
            rf_data_in <= '0;
        end else if (xfer) begin
            rf_wr_en   <= sel.wr_en;
            rf_rd_en   <= sel.rd_en;
            rf_wr_addr <= sel.wr_addr;
            rf_rd_addr <= sel.rd_addr;
            rf_data_in <= sel.wdata;
        end else begin
            rf_wr_en <= 2'b00;
            rf_rd_en <= 2'b00;
        end
    end

    rf_rsp_pipe u_rsp_pipe (
        .clock       (clock),
        .reset       (reset),
        .acc_valid   (xfer && (|sel.rd_en)),
        .acc_port    (grant[1]),
        .acc_rd_en   (sel.rd_en),
        .rf_data_out (rf_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata)
    );

endmodule
